slot_game_ctrl: RTL and testbench
=================================

Name: slot_game_ctrl

Overview:
Parametrised game controller for the slot-machine demo. It owns the credit balance, accepts bets, spins NUM_REELS reels and stops them one at a time on stop request, then applies a payout table. Replaces the fixed 4-reel random generator and bank pair. Its reel outputs feed the 7-segment and VGA display paths.

Parameters:
NUM_REELS, 4, number of reels (2..8)
SYM_W, 4, bits per reel symbol
NUM_SYMBOLS, 10, symbols per reel; reel values are 0..NUM_SYMBOLS-1
BAL_W, 27, balance/credit/bet width
STOP_GAP, 4, ticks between successive reel freezes (>=1)
PAIR_MULT, 2, payout multiplier when reel0==reel1 (not jackpot)
JACKPOT_MULT, 50, payout multiplier when all reels are equal

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  reel-advance enable, one-cycle pulse (slot clock rate)
credit_valid  in  1  add credit_amt this cycle
credit_amt  in  BAL_W  credit value (coin inputs pre-encoded)
bet_valid  in  1  bet request
bet_amt  in  BAL_W  bet value
stop_req  in  1  stop request (debounced pulse)
bet_reject  out  1  one-cycle pulse, bet refused
reels  out  NUM_REELS*SYM_W  reel i at bits [i*SYM_W +: SYM_W]
frozen  out  NUM_REELS  bit i high once reel i has stopped
balance  out  BAL_W  current credit
win_valid  out  1  one-cycle pulse at payout
win_amt  out  BAL_W  payout value, held until the next payout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE; reels=0; frozen=0; balance=0; win_amt=0; all pulse outputs low. Takes effect mid-spin, with no payout.
- FSM IDLE -> SPIN -> STOPPING -> PAYOUT -> IDLE.
- IDLE, bet_valid:
  - Accept if 0 < bet_amt <= balance (pre-credit value of the same cycle).
  - On accept: next cycle balance -= bet_amt, bet latched, frozen=0, state=SPIN.
  - Otherwise: bet_reject pulses next cycle and state stays IDLE.
- bet_valid outside IDLE is ignored, with no reject pulse.
- Reel advance: on tick, every non-frozen reel i steps by (i+1) modulo NUM_SYMBOLS, wrapping correctly. Reels hold their value in IDLE.
- SPIN: reels advance on tick. stop_req -> STOPPING next cycle, with gap counter=0 and stop index=0. stop_req in other states is ignored.
- STOPPING, on each tick:
  - Non-frozen reels advance first, then the gap counter increments.
  - When the counter reaches STOP_GAP, the reel at the stop index freezes at its just-advanced value, the counter clears and the index increments.
  - After reel NUM_REELS-1 freezes -> PAYOUT.
- PAYOUT (one cycle):
  - All reels equal -> win = bet*JACKPOT_MULT.
  - Else reel0==reel1 -> win = bet*PAIR_MULT.
  - Else win = 0.
  - Jackpot has priority over pair.
  - Products are computed at BAL_W+8 bits and saturated to 2^BAL_W-1.
  - Next cycle: win_valid=1, win_amt=win, balance += win (saturating), state=IDLE.
- Credit: accepted in any state, balance += credit_amt, saturating at 2^BAL_W-1.
- Same-cycle events: credit, bet debit and payout credit combine into one update: balance + credit - bet + win. The sum is computed at BAL_W+2 bits and saturated.
- Latency: input to registered output is 1 cycle for balance, state, bet_reject and win_valid.

Optional Feature:
AUTO_STOP_EN: when defined, adds parameter AUTO_STOP_TICKS (default 64). SPIN enters STOPPING automatically after AUTO_STOP_TICKS ticks with no stop_req, and stop_req still stops earlier. When undefined, SPIN persists until stop_req.

Decomposition:
- Package slot_pkg: state enum (IDLE, SPIN, STOPPING, PAYOUT), default multiplier constants, saturating-add helper function.
- One sub-module, slot_reel: modulo-NUM_SYMBOLS counter with stride, advance enable, freeze and clear. It is instantiated NUM_REELS times via generate.

Test Plan:
- Reset, credit 100, bet 0, bet 200 -> two bet_reject pulses, balance stays 100, busy=0.
- Jackpot: NUM_SYMBOLS=10, STOP_GAP=10, credit 100, bet 10, stop_req with 0 SPIN ticks, tick every cycle -> reels 0,0,0,0; win_amt=500; balance=590.
- Pair: STOP_GAP=1, bet 10 from balance 100, 7 SPIN ticks then stop_req -> reels 8,8,0,4; win_amt=20; balance=110.
- Loss: STOP_GAP=5, 0 SPIN ticks -> reels 5,0,5,0; win_valid with win_amt=0; balance=90.
- Saturation and simultaneity: balance 2^27-5, credit 10 in the same cycle as a bet of 3 -> balance=2^27-1. Also credit arriving in the PAYOUT cycle is summed with the win.
- Reset asserted in STOPPING -> next cycle IDLE, reels=0, balance=0, no win_valid. With AUTO_STOP_EN and AUTO_STOP_TICKS=8 -> STOPPING entered after 8 ticks with no stop_req.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared constants and helpers for the slot-machine game controller.
package slot_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SPIN     = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;
  localparam logic [1:0] PAYOUT   = 2'd3;

  localparam int unsigned DEF_PAIR_MULT    = 2;
  localparam int unsigned DEF_JACKPOT_MULT = 50;

  // Clamp an unsigned value to the largest w-bit number.
  function automatic logic [63:0] sat_max(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/slot_reel.sv
// One reel: modulo-NUM_SYMBOLS counter stepping by STRIDE, with freeze and freeze-clear.
module slot_reel
#(
  parameter int unsigned NUM_SYMBOLS = 10,
  parameter int unsigned SYM_W       = 4,
  parameter int unsigned STRIDE      = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             freeze,
  input  logic             clear,
  output logic [SYM_W-1:0] value,
  output logic             frozen
);

  localparam int unsigned SW = SYM_W + 1;
  localparam logic [SW-1:0] STEP_V = SW'(STRIDE % NUM_SYMBOLS);
  localparam logic [SW-1:0] MOD_V  = SW'(NUM_SYMBOLS);

  logic [SW-1:0]    sum_c;
  logic [SYM_W-1:0] next_c;

  // Value and step are both below NUM_SYMBOLS, so one subtraction wraps.
  always_comb begin
    sum_c  = {1'b0, value} + STEP_V;
    next_c = (sum_c >= MOD_V) ? SYM_W'(sum_c - MOD_V) : SYM_W'(sum_c);
  end

  // Freeze takes the value advanced in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= '0;
      frozen <= 1'b0;
    end else begin
      if (adv && !frozen) value <= next_c;
      if (freeze)         frozen <= 1'b1;
      else if (clear)     frozen <= 1'b0;
    end
  end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: credit balance, bets, reel spin/stop and payout.
// Optional `AUTO_STOP_EN adds AUTO_STOP_TICKS, ending SPIN automatically.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned NUM_REELS    = 4,
  parameter int unsigned SYM_W        = 4,
  parameter int unsigned NUM_SYMBOLS  = 10,
  parameter int unsigned BAL_W        = 27,
  parameter int unsigned STOP_GAP     = 4,
  parameter int unsigned PAIR_MULT    = DEF_PAIR_MULT,
  parameter int unsigned JACKPOT_MULT = DEF_JACKPOT_MULT
`ifdef AUTO_STOP_EN
  ,
  parameter int unsigned AUTO_STOP_TICKS = 64
`endif
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       credit_valid,
  input  logic [BAL_W-1:0]           credit_amt,
  input  logic                       bet_valid,
  input  logic [BAL_W-1:0]           bet_amt,
  input  logic                       stop_req,
  output logic                       bet_reject,
  output logic [NUM_REELS*SYM_W-1:0] reels,
  output logic [NUM_REELS-1:0]       frozen,
  output logic [BAL_W-1:0]           balance,
  output logic                       win_valid,
  output logic [BAL_W-1:0]           win_amt,
  output logic                       busy
);

  localparam int unsigned PW    = BAL_W + 8;
  localparam int unsigned SW    = BAL_W + 2;
  localparam int unsigned GAP_W = $clog2(STOP_GAP + 1);
  localparam int unsigned IDX_W = $clog2(NUM_REELS);

  logic [1:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BAL_W-1:0] bet_q, bet_d;
  logic [BAL_W-1:0] balance_d;
  logic             bet_rej_d;

`ifdef AUTO_STOP_EN
  localparam int unsigned AW = $clog2(AUTO_STOP_TICKS + 1);
  logic [AW-1:0] spin_cnt_q, spin_cnt_d;
`endif

  logic                 adv_c;
  logic                 clear_c;
  logic [NUM_REELS-1:0] freeze_c;
  logic                 bet_ok;
  logic                 pay;

  logic [SYM_W-1:0] reel_val [NUM_REELS];
  logic             all_eq;
  logic [PW-1:0]    prod_jack, prod_pair;
  logic [BAL_W-1:0] win_c;
  logic [BAL_W-1:0] credit_add, win_add, bet_sub;
  logic [SW-1:0]    bal_sum;

  // Reel bank: reel i steps by i+1 per tick while not frozen.
  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    slot_reel #(
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .SYM_W       (SYM_W),
      .STRIDE      (i + 1)
    ) u_reel (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv_c),
      .freeze (freeze_c[i]),
      .clear  (clear_c),
      .value  (reel_val[i]),
      .frozen (frozen[i])
    );
    assign reels[i*SYM_W +: SYM_W] = reel_val[i];
  end

  // Payout evaluation on the frozen reels; jackpot outranks pair.
  always_comb begin
    all_eq = 1'b1;
    for (int unsigned i = 1; i < NUM_REELS; i++) begin
      if (reel_val[i] != reel_val[0]) all_eq = 1'b0;
    end
    prod_jack = PW'(bet_q) * PW'(JACKPOT_MULT);
    prod_pair = PW'(bet_q) * PW'(PAIR_MULT);
    if (all_eq)                         win_c = BAL_W'(sat_max(64'(prod_jack), BAL_W));
    else if (reel_val[0] == reel_val[1]) win_c = BAL_W'(sat_max(64'(prod_pair), BAL_W));
    else                                win_c = '0;
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    bet_d     = bet_q;
    bet_rej_d = 1'b0;
    bet_ok    = 1'b0;
    pay       = 1'b0;
    clear_c   = 1'b0;
    freeze_c  = '0;
    gap_inc   = gap_q + GAP_W'(1);
    adv_c     = tick && ((state_q == SPIN) || (state_q == STOPPING));
`ifdef AUTO_STOP_EN
    spin_cnt_d = spin_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bet_valid) begin
          if ((bet_amt != '0) && (bet_amt <= balance)) begin
            bet_ok  = 1'b1;
            bet_d   = bet_amt;
            clear_c = 1'b1;
            state_d = SPIN;
`ifdef AUTO_STOP_EN
            spin_cnt_d = '0;
`endif
          end else begin
            bet_rej_d = 1'b1;
          end
        end
      end
      SPIN: begin
        if (stop_req) begin
          state_d = STOPPING;
          gap_d   = '0;
          idx_d   = '0;
        end
`ifdef AUTO_STOP_EN
        else if (tick) begin
          if (spin_cnt_q + AW'(1) == AW'(AUTO_STOP_TICKS)) begin
            state_d = STOPPING;
            gap_d   = '0;
            idx_d   = '0;
          end else begin
            spin_cnt_d = spin_cnt_q + AW'(1);
          end
        end
`endif
      end
      STOPPING: begin
        if (tick) begin
          if (gap_inc == GAP_W'(STOP_GAP)) begin
            freeze_c = NUM_REELS'(1) << idx_q;
            gap_d    = '0;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_REELS - 1)) state_d = PAYOUT;
          end else begin
            gap_d = gap_inc;
          end
        end
      end
      PAYOUT: begin
        pay     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Credit, bet debit and payout merge into one saturated update.
    credit_add = credit_valid ? credit_amt : '0;
    win_add    = pay ? win_c : '0;
    bet_sub    = bet_ok ? bet_amt : '0;
    bal_sum    = SW'(balance) + SW'(credit_add) + SW'(win_add) - SW'(bet_sub);
    balance_d  = BAL_W'(sat_max(64'(bal_sum), BAL_W));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      idx_q      <= '0;
      bet_q      <= '0;
      balance    <= '0;
      bet_reject <= 1'b0;
      win_valid  <= 1'b0;
      win_amt    <= '0;
      busy       <= 1'b0;
`ifdef AUTO_STOP_EN
      spin_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      bet_q      <= bet_d;
      balance    <= balance_d;
      bet_reject <= bet_rej_d;
      win_valid  <= pay;
      if (pay) win_amt <= win_c;
      busy       <= (state_d != IDLE);
`ifdef AUTO_STOP_EN
      spin_cnt_q <= spin_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed self-checking bench for slot_game_ctrl; three instances differ only in STOP_GAP.
module tb_slot_game_ctrl;

  localparam int unsigned GAPS [3] = '{10, 1, 5};
  localparam logic [26:0] MAXB = 27'h7FF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        credit_valid = 1'b0;
  logic [26:0] credit_amt = '0;
  logic        bet_valid = 1'b0;
  logic [26:0] bet_amt = '0;
  logic        stop_req = 1'b0;

  logic        bet_reject_o [3];
  logic [15:0] reels_o [3];
  logic [3:0]  frozen_o [3];
  logic [26:0] balance_o [3];
  logic        win_valid_o [3];
  logic [26:0] win_amt_o [3];
  logic        busy_o [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    slot_game_ctrl #(
      .NUM_REELS(4), .SYM_W(4), .NUM_SYMBOLS(10), .BAL_W(27),
      .STOP_GAP(GAPS[g]), .PAIR_MULT(2), .JACKPOT_MULT(50)
    ) u_dut (
      .clk(clk), .rst(rst), .tick(tick),
      .credit_valid(credit_valid), .credit_amt(credit_amt),
      .bet_valid(bet_valid), .bet_amt(bet_amt), .stop_req(stop_req),
      .bet_reject(bet_reject_o[g]), .reels(reels_o[g]), .frozen(frozen_o[g]),
      .balance(balance_o[g]), .win_valid(win_valid_o[g]), .win_amt(win_amt_o[g]),
      .busy(busy_o[g])
    );
  end

`ifdef AUTO_STOP_EN
  logic        bet_reject_a, win_valid_a, busy_a;
  logic [15:0] reels_a;
  logic [3:0]  frozen_a;
  logic [26:0] balance_a, win_amt_a;

  slot_game_ctrl #(
    .NUM_REELS(4), .SYM_W(4), .NUM_SYMBOLS(10), .BAL_W(27),
    .STOP_GAP(1), .PAIR_MULT(2), .JACKPOT_MULT(50), .AUTO_STOP_TICKS(8)
  ) u_auto (
    .clk(clk), .rst(rst), .tick(tick),
    .credit_valid(credit_valid), .credit_amt(credit_amt),
    .bet_valid(bet_valid), .bet_amt(bet_amt), .stop_req(stop_req),
    .bet_reject(bet_reject_a), .reels(reels_a), .frozen(frozen_a),
    .balance(balance_a), .win_valid(win_valid_a), .win_amt(win_amt_a),
    .busy(busy_a)
  );
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; tick = 1'b0; credit_valid = 1'b0; bet_valid = 1'b0; stop_req = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic credit(input logic [26:0] amt);
    credit_valid = 1'b1; credit_amt = amt;
    cyc();
    credit_valid = 1'b0;
  endtask

  task automatic bet(input logic [26:0] amt);
    bet_valid = 1'b1; bet_amt = amt;
    cyc();
    bet_valid = 1'b0;
  endtask

  task automatic spin_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic stop;
    stop_req = 1'b1;
    cyc();
    stop_req = 1'b0;
  endtask

  // Ticks every cycle until instance g shows all reels frozen (PAYOUT), then
  // optionally credits during PAYOUT and steps to the win cycle.
  task automatic run_to_payout(input int g, input logic [26:0] extra);
    bit seen = 0;
    tick = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      if (frozen_o[g] == 4'hF) seen = 1;
    end
    tick = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL payout_wait[%0d]: frozen=%h never reached expected f", g, frozen_o[g]);
    end
    credit_valid = (extra != '0);
    credit_amt   = extra;
    cyc();
    credit_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy_o[0]); end
    tests++; if (balance_o[0] !== 27'd0) begin fails++; $display("FAIL reset_balance: got %0d expected 0", balance_o[0]); end
    tests++; if (reels_o[0] !== 16'h0) begin fails++; $display("FAIL reset_reels: got %h expected 0000", reels_o[0]); end
    tests++; if (frozen_o[0] !== 4'h0) begin fails++; $display("FAIL reset_frozen: got %h expected 0", frozen_o[0]); end
    tests++; if (win_valid_o[0] !== 1'b0 || bet_reject_o[0] !== 1'b0) begin fails++; $display("FAIL reset_pulses: got win_valid=%0b bet_reject=%0b expected 0 0", win_valid_o[0], bet_reject_o[0]); end
  endtask

  task automatic test_reject;
    do_reset();
    credit(27'd100);
    tests++; if (balance_o[0] !== 27'd100) begin fails++; $display("FAIL credit_100: got %0d expected 100", balance_o[0]); end
    bet(27'd0);
    tests++; if (bet_reject_o[0] !== 1'b1) begin fails++; $display("FAIL reject_zero: got %0b expected 1", bet_reject_o[0]); end
    cyc();
    tests++; if (bet_reject_o[0] !== 1'b0) begin fails++; $display("FAIL reject_pulse_end: got %0b expected 0", bet_reject_o[0]); end
    bet(27'd200);
    tests++; if (bet_reject_o[0] !== 1'b1) begin fails++; $display("FAIL reject_over: got %0b expected 1", bet_reject_o[0]); end
    tests++; if (balance_o[0] !== 27'd100) begin fails++; $display("FAIL reject_balance: got %0d expected 100", balance_o[0]); end
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL reject_busy: got %0b expected 0", busy_o[0]); end
    stop();
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL idle_stop_ignored: busy got %0b expected 0", busy_o[0]); end
  endtask

  task automatic test_jackpot;
    do_reset();
    credit(27'd100);
    bet(27'd10);
    tests++; if (balance_o[0] !== 27'd90) begin fails++; $display("FAIL jack_debit: got %0d expected 90", balance_o[0]); end
    tests++; if (busy_o[0] !== 1'b1) begin fails++; $display("FAIL jack_busy: got %0b expected 1", busy_o[0]); end
    stop();
    run_to_payout(0, 27'd0);
    tests++; if (reels_o[0] !== 16'h0000) begin fails++; $display("FAIL jack_reels: got %h expected 0000", reels_o[0]); end
    tests++; if (win_valid_o[0] !== 1'b1) begin fails++; $display("FAIL jack_win_valid: got %0b expected 1", win_valid_o[0]); end
    tests++; if (win_amt_o[0] !== 27'd500) begin fails++; $display("FAIL jack_win_amt: got %0d expected 500", win_amt_o[0]); end
    tests++; if (balance_o[0] !== 27'd590) begin fails++; $display("FAIL jack_balance: got %0d expected 590", balance_o[0]); end
    cyc();
    tests++; if (win_valid_o[0] !== 1'b0 || win_amt_o[0] !== 27'd500 || busy_o[0] !== 1'b0) begin fails++; $display("FAIL jack_after: got win_valid=%0b win_amt=%0d busy=%0b expected 0 500 0", win_valid_o[0], win_amt_o[0], busy_o[0]); end
  endtask

  task automatic test_pair;
    do_reset();
    credit(27'd100);
    bet(27'd10);
    spin_ticks(7);
    tests++; if (reels_o[1] !== 16'h8147) begin fails++; $display("FAIL spin_reels: got %h expected 8147", reels_o[1]); end
    bet(27'd5);
    tests++; if (bet_reject_o[1] !== 1'b0 || balance_o[1] !== 27'd90) begin fails++; $display("FAIL spin_bet_ignored: got reject=%0b balance=%0d expected 0 90", bet_reject_o[1], balance_o[1]); end
    stop();
    run_to_payout(1, 27'd0);
    tests++; if (reels_o[1] !== 16'h4088) begin fails++; $display("FAIL pair_reels: got %h expected 4088", reels_o[1]); end
    tests++; if (win_valid_o[1] !== 1'b1 || win_amt_o[1] !== 27'd20) begin fails++; $display("FAIL pair_win: got valid=%0b amt=%0d expected 1 20", win_valid_o[1], win_amt_o[1]); end
    tests++; if (balance_o[1] !== 27'd110) begin fails++; $display("FAIL pair_balance: got %0d expected 110", balance_o[1]); end
  endtask

  task automatic test_loss;
    do_reset();
    credit(27'd100);
    bet(27'd10);
    stop();
    run_to_payout(2, 27'd0);
    tests++; if (reels_o[2] !== 16'h0505) begin fails++; $display("FAIL loss_reels: got %h expected 0505", reels_o[2]); end
    tests++; if (win_valid_o[2] !== 1'b1 || win_amt_o[2] !== 27'd0) begin fails++; $display("FAIL loss_win: got valid=%0b amt=%0d expected 1 0", win_valid_o[2], win_amt_o[2]); end
    tests++; if (balance_o[2] !== 27'd90) begin fails++; $display("FAIL loss_balance: got %0d expected 90", balance_o[2]); end
  endtask

  // Second game straight after the loss; reels 5,0,5,0 land on 0,0,0,0 with credit in PAYOUT.
  task automatic test_back_to_back;
    bet(27'd10);
    tests++; if (balance_o[2] !== 27'd80) begin fails++; $display("FAIL b2b_debit: got %0d expected 80", balance_o[2]); end
    stop();
    run_to_payout(2, 27'd7);
    tests++; if (reels_o[2] !== 16'h0000) begin fails++; $display("FAIL b2b_reels: got %h expected 0000", reels_o[2]); end
    tests++; if (win_amt_o[2] !== 27'd500) begin fails++; $display("FAIL b2b_win: got %0d expected 500", win_amt_o[2]); end
    tests++; if (balance_o[2] !== 27'd587) begin fails++; $display("FAIL b2b_balance: got %0d expected 587", balance_o[2]); end
  endtask

  task automatic test_saturation;
    do_reset();
    credit(MAXB - 27'd4);
    tests++; if (balance_o[0] !== MAXB - 27'd4) begin fails++; $display("FAIL sat_load: got %0d expected %0d", balance_o[0], MAXB - 27'd4); end
    credit_valid = 1'b1; credit_amt = 27'd10;
    bet_valid = 1'b1; bet_amt = 27'd3;
    cyc();
    credit_valid = 1'b0; bet_valid = 1'b0;
    tests++; if (balance_o[0] !== MAXB) begin fails++; $display("FAIL sat_combined: got %0d expected %0d", balance_o[0], MAXB); end
    tests++; if (busy_o[0] !== 1'b1) begin fails++; $display("FAIL sat_bet_accept: busy got %0b expected 1", busy_o[0]); end
    credit(MAXB);
    tests++; if (balance_o[0] !== MAXB) begin fails++; $display("FAIL sat_credit: got %0d expected %0d", balance_o[0], MAXB); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    credit(27'd100);
    bet(27'd10);
    stop();
    spin_ticks(12);
    tests++; if (frozen_o[0] !== 4'b0001) begin fails++; $display("FAIL mid_frozen: got %b expected 0001", frozen_o[0]); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++; if (busy_o[0] !== 1'b0 || balance_o[0] !== 27'd0) begin fails++; $display("FAIL mid_reset_state: got busy=%0b balance=%0d expected 0 0", busy_o[0], balance_o[0]); end
    tests++; if (reels_o[0] !== 16'h0 || frozen_o[0] !== 4'h0) begin fails++; $display("FAIL mid_reset_reels: got reels=%h frozen=%h expected 0000 0", reels_o[0], frozen_o[0]); end
    spin_ticks(45);
    tests++; if (win_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin fails++; $display("FAIL mid_no_payout: got win_valid=%0b busy=%0b expected 0 0", win_valid_o[0], busy_o[0]); end
  endtask

`ifdef AUTO_STOP_EN
  task automatic test_auto_stop;
    do_reset();
    credit(27'd100);
    bet(27'd10);
    spin_ticks(7);
    tests++; if (frozen_a !== 4'h0) begin fails++; $display("FAIL auto_early: frozen got %h expected 0", frozen_a); end
    spin_ticks(1);
    spin_ticks(1);
    tests++; if (frozen_a !== 4'b0001) begin fails++; $display("FAIL auto_stop: frozen got %b expected 0001", frozen_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_reject();
    test_jackpot();
    test_pair();
    test_loss();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
`ifdef AUTO_STOP_EN
    test_auto_stop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
